// File: rtl/data_memory_controller.sv
// Data memory port owner: routes MEM-stage accesses while the CPU runs and,
// on a debug request while halted, streams every memory word out as bytes, LSB first.
module data_memory_controller #(
  parameter int ADDR_SIZE = 5,
  parameter int SLOT_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cpu_halted,
  input  logic                 i_cpu_wr_rd,
  input  logic [ADDR_SIZE-1:0] i_cpu_addr,
  input  logic [SLOT_SIZE-1:0] i_cpu_data,
  output logic [SLOT_SIZE-1:0] o_cpu_data,
  output logic                 o_mem_wr_rd,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [SLOT_SIZE-1:0] o_mem_data,
  input  logic [SLOT_SIZE-1:0] i_mem_data,
  input  logic                 i_dump_start,
  output logic                 o_tx_valid,
  output logic [BYTE_SIZE-1:0] o_tx_data,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_dump_done
);

  localparam int BYTES  = SLOT_SIZE / BYTE_SIZE;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCNT_W-1:0]    LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t               state, state_next;
  logic [ADDR_SIZE-1:0] addr_cnt;
  logic [BCNT_W-1:0]    byte_cnt;
  logic [SLOT_SIZE-1:0] word_reg;
  logic [BYTE_SIZE-1:0] lane [BYTES];
  logic                 start_ok;
  logic                 tx_hs;
  logic                 last_byte;
  logic                 last_addr;

  assign start_ok  = i_dump_start & i_cpu_halted;
  assign tx_hs     = (state == SEND) & i_tx_ready;
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_addr = (addr_cnt == LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (tx_hs && last_byte) state_next = last_addr ? DONE : LOAD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address only advances after the last byte of a non-final slot, so it never wraps.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_cnt <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_ok) addr_cnt <= '0;
        LOAD: begin
          word_reg <= i_mem_data;
          byte_cnt <= '0;
        end
        SEND: if (tx_hs) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (last_byte && !last_addr) addr_cnt <= addr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < BYTES; i++) lane[i] = word_reg[i*BYTE_SIZE +: BYTE_SIZE];
  end

  assign o_tx_valid  = (state == SEND);
  assign o_tx_data   = o_tx_valid ? lane[byte_cnt] : '0;
  assign o_busy      = (state != IDLE);
  assign o_dump_done = (state == DONE);
  assign o_cpu_data  = i_mem_data;

  // The memory port belongs to the dump engine whenever it is not idle.
  always_comb begin
    if (state == IDLE) begin
      o_mem_wr_rd = i_cpu_wr_rd & ~i_cpu_halted & ~i_reset;
      o_mem_addr  = i_cpu_addr;
      o_mem_data  = i_cpu_data;
    end else begin
      o_mem_wr_rd = 1'b0;
      o_mem_addr  = addr_cnt;
      o_mem_data  = '0;
    end
  end

endmodule

// File: tb/tb_data_memory_controller.sv
// Bench for data_memory_controller: behavioural data memory, scoreboard of
// expected dump bytes, per-scenario tasks.
module tb_data_memory_controller;

  localparam int AW = 5;
  localparam int SW = 32;
  localparam int BW = 8;
  localparam int NBYTES = (2**AW) * (SW/BW);

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_cpu_halted;
  logic          i_cpu_wr_rd;
  logic [AW-1:0] i_cpu_addr;
  logic [SW-1:0] i_cpu_data;
  logic [SW-1:0] o_cpu_data;
  logic          o_mem_wr_rd;
  logic [AW-1:0] o_mem_addr;
  logic [SW-1:0] o_mem_data;
  logic [SW-1:0] i_mem_data;
  logic          i_dump_start;
  logic          o_tx_valid;
  logic [BW-1:0] o_tx_data;
  logic          i_tx_ready;
  logic          o_busy;
  logic          o_dump_done;

  logic [SW-1:0] mem [2**AW];
  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] got_q [$];
  logic [BW-1:0] ref_q [$];
  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_memory_controller #(.ADDR_SIZE(AW), .SLOT_SIZE(SW), .BYTE_SIZE(BW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_cpu_halted(i_cpu_halted),
    .i_cpu_wr_rd(i_cpu_wr_rd), .i_cpu_addr(i_cpu_addr), .i_cpu_data(i_cpu_data),
    .o_cpu_data(o_cpu_data), .o_mem_wr_rd(o_mem_wr_rd), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .i_dump_start(i_dump_start),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_dump_done(o_dump_done)
  );

  // Behavioural data memory: combinational read, clocked write.
  assign i_mem_data = mem[o_mem_addr];
  always @(posedge clk) if (o_mem_wr_rd) mem[o_mem_addr] <= o_mem_data;

  function automatic logic [SW-1:0] slot_val(input int n);
    return SW'(n) * 32'h0101_0101 + 32'h10;
  endfunction

  task automatic push_expected();
    logic [SW-1:0] w;
    exp_q.delete();
    for (int n = 0; n < 2**AW; n++) begin
      w = slot_val(n);
      for (int b = 0; b < SW/BW; b++) exp_q.push_back(w[b*BW +: BW]);
    end
  endtask

  task automatic preload();
    i_cpu_halted = 1'b0;
    for (int n = 0; n < 2**AW; n++) begin
      @(negedge clk);
      i_cpu_wr_rd = 1'b1;
      i_cpu_addr  = AW'(n);
      i_cpu_data  = slot_val(n);
    end
    @(negedge clk);
    i_cpu_wr_rd = 1'b0;
  endtask

  // Starts a dump and records accepted bytes into got_q; returns early, with
  // ready low, once stop_after bytes have been accepted and the next is valid.
  task automatic run_dump(input int duty, input int stop_after, input int restart_at,
                          output int done_cycle, output int done_cnt, output int first_valid,
                          output int stall_viol, output int wr_viol, output bit timeout);
    int c;
    bit stalled, restarted;
    logic [BW-1:0] stall_data;
    got_q.delete();
    done_cycle = -1; done_cnt = 0; first_valid = -1; stall_viol = 0; wr_viol = 0;
    stalled = 1'b0; restarted = 1'b0; stall_data = '0; timeout = 1'b0;
    @(negedge clk);
    i_cpu_halted = 1'b1; i_cpu_wr_rd = 1'b1; i_cpu_data = '1; i_dump_start = 1'b1;
    i_tx_ready = (duty >= 100);
    @(posedge clk);
    c = 1;
    @(negedge clk);
    i_dump_start = 1'b0;
    while (c < 4000) begin
      if (stop_after >= 0 && got_q.size() == stop_after && o_tx_valid) begin
        i_tx_ready = 1'b0;
        return;
      end
      if (restart_at >= 0 && !restarted && got_q.size() == restart_at && o_tx_valid) begin
        i_dump_start = 1'b1;
        restarted = 1'b1;
      end else begin
        i_dump_start = 1'b0;
      end
      i_cpu_addr = AW'($urandom_range(31));
      i_tx_ready = ($urandom_range(99) < duty);
      if (o_mem_wr_rd) wr_viol++;
      if (o_tx_valid && first_valid < 0) first_valid = c;
      if (stalled && o_tx_valid && o_tx_data !== stall_data) stall_viol++;
      stalled = o_tx_valid && !i_tx_ready;
      stall_data = o_tx_data;
      if (o_dump_done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (o_tx_valid && i_tx_ready) got_q.push_back(o_tx_data);
      if (done_cnt > 0 && c >= done_cycle + 3) break;
      @(posedge clk);
      c++;
      @(negedge clk);
    end
    i_dump_start = 1'b0;
    i_cpu_wr_rd  = 1'b0;
    timeout = (done_cnt == 0);
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_cpu_halted = 1'b0; i_cpu_wr_rd = 1'b1; i_cpu_addr = '0;
    i_cpu_data = '0; i_dump_start = 1'b0; i_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    applied++;
    if ({o_tx_valid, o_busy, o_dump_done, o_mem_wr_rd} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b expected 0000", {o_tx_valid, o_busy, o_dump_done, o_mem_wr_rd});
    end
    applied++;
    if (o_tx_data !== '0) begin
      miscompares++;
      $display("FAIL reset_txdata got %0h expected 0", o_tx_data);
    end
    i_cpu_wr_rd = 1'b0;
    i_reset = 1'b0;
  endtask

  task automatic test_passthrough();
    int busy_seen;
    @(negedge clk);
    i_cpu_halted = 1'b0; i_cpu_wr_rd = 1'b1; i_cpu_addr = 5'd3; i_cpu_data = 32'hDEAD_BEEF;
    #1;
    applied++;
    if ({o_mem_wr_rd, o_mem_addr, o_mem_data} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL pass_write got wr=%b a=%0d d=%0h expected wr=1 a=3 d=deadbeef",
               o_mem_wr_rd, o_mem_addr, o_mem_data);
    end
    busy_seen = o_busy;
    @(negedge clk);
    i_cpu_wr_rd = 1'b0;
    #1;
    busy_seen += o_busy;
    applied++;
    if (o_cpu_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL pass_read got %0h expected deadbeef", o_cpu_data);
    end
    applied++;
    if (busy_seen != 0) begin
      miscompares++;
      $display("FAIL pass_busy got %0d busy cycles expected 0", busy_seen);
    end
    @(negedge clk);
    i_cpu_halted = 1'b1; i_cpu_wr_rd = 1'b1; i_cpu_addr = 5'd9;
    #1;
    applied++;
    if ({o_mem_wr_rd, o_mem_addr} !== {1'b0, 5'd9}) begin
      miscompares++;
      $display("FAIL halted_write got wr=%b a=%0d expected wr=0 a=9", o_mem_wr_rd, o_mem_addr);
    end
    @(negedge clk);
    i_cpu_wr_rd = 1'b0;
  endtask

  task automatic test_blocked_start();
    int bad;
    bad = 0;
    @(negedge clk);
    i_cpu_halted = 1'b0; i_dump_start = 1'b1;
    @(negedge clk);
    i_dump_start = 1'b0;
    repeat (10) begin
      if (o_busy || o_tx_valid || o_dump_done) bad++;
      @(negedge clk);
    end
    applied++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL blocked_start got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_full_dump();
    int dc, dn, fv, sv, wv, n;
    bit to;
    logic [BW-1:0] e, g;
    push_expected();
    run_dump(100, -1, -1, dc, dn, fv, sv, wv, to);
    ref_q = got_q;
    applied++;
    if (to) begin miscompares++; $display("FAIL full_timeout got no done pulse expected one"); end
    applied++;
    if (dc != 161) begin miscompares++; $display("FAIL full_done_cycle got %0d expected 161", dc); end
    applied++;
    if (dn != 1) begin miscompares++; $display("FAIL full_done_count got %0d expected 1", dn); end
    applied++;
    if (fv != 2) begin miscompares++; $display("FAIL full_first_valid got %0d expected 2", fv); end
    applied++;
    if (wv != 0) begin miscompares++; $display("FAIL full_mem_write got %0d expected 0", wv); end
    applied++;
    if (got_q.size() != NBYTES) begin
      miscompares++;
      $display("FAIL full_byte_count got %0d expected %0d", got_q.size(), NBYTES);
    end
    n = 0;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      applied++;
      if (g !== e) begin miscompares++; $display("FAIL full_byte[%0d] got %0h expected %0h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_backpressure();
    int dc, dn, fv, sv, wv, diffs, n;
    bit to;
    logic [BW-1:0] e, g;
    push_expected();
    run_dump(30, -1, -1, dc, dn, fv, sv, wv, to);
    applied++;
    if (to || dn != 1) begin
      miscompares++;
      $display("FAIL bp_done got count=%0d timeout=%0b expected count=1", dn, to);
    end
    applied++;
    if (sv != 0) begin miscompares++; $display("FAIL bp_stall_change got %0d expected 0", sv); end
    applied++;
    if (wv != 0) begin miscompares++; $display("FAIL bp_mem_write got %0d expected 0", wv); end
    diffs = (got_q.size() == ref_q.size()) ? 0 : 1;
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) if (got_q[i] !== ref_q[i]) diffs++;
    applied++;
    if (diffs != 0) begin miscompares++; $display("FAIL bp_vs_ready_run got %0d diffs expected 0", diffs); end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      applied++;
      if (g !== e) begin miscompares++; $display("FAIL bp_byte[%0d] got %0h expected %0h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid_dump();
    int dc, dn, fv, sv, wv, bad, n;
    bit to;
    logic [BW-1:0] e, g;
    push_expected();
    run_dump(100, 30, -1, dc, dn, fv, sv, wv, to);
    applied++;
    if (!o_tx_valid || o_tx_data !== exp_q[30]) begin
      miscompares++;
      $display("FAIL mid_slot7_byte2 got v=%b d=%0h expected v=1 d=%0h", o_tx_valid, o_tx_data, exp_q[30]);
    end
    i_cpu_wr_rd = 1'b1;
    i_reset = 1'b1;
    #1;
    applied++;
    if ({o_tx_valid, o_busy, o_dump_done, o_mem_wr_rd} !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl got %b expected 0000", {o_tx_valid, o_busy, o_dump_done, o_mem_wr_rd});
    end
    @(negedge clk);
    i_cpu_wr_rd = 1'b0;
    i_reset = 1'b0;
    bad = 0;
    repeat (10) begin
      if (o_busy || o_tx_valid || o_dump_done) bad++;
      @(negedge clk);
    end
    applied++;
    if (bad != 0) begin miscompares++; $display("FAIL mid_after_reset got %0d active cycles expected 0", bad); end
    run_dump(100, -1, -1, dc, dn, fv, sv, wv, to);
    applied++;
    if (dn != 1 || dc != 161) begin
      miscompares++;
      $display("FAIL mid_restart got done=%0d at %0d expected 1 at 161", dn, dc);
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      applied++;
      if (g !== e) begin miscompares++; $display("FAIL mid_byte[%0d] got %0h expected %0h", n, g, e); end
      n++;
    end
  endtask

  task automatic test_start_while_busy();
    int dc, dn, fv, sv, wv;
    bit to;
    int diffs;
    push_expected();
    run_dump(100, -1, 48, dc, dn, fv, sv, wv, to);
    applied++;
    if (dn != 1 || dc != 161) begin
      miscompares++;
      $display("FAIL busy_start_done got done=%0d at %0d expected 1 at 161", dn, dc);
    end
    applied++;
    if (got_q.size() != NBYTES) begin
      miscompares++;
      $display("FAIL busy_start_count got %0d expected %0d", got_q.size(), NBYTES);
    end
    diffs = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) diffs++;
    applied++;
    if (diffs != 0) begin miscompares++; $display("FAIL busy_start_stream got %0d diffs expected 0", diffs); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_blocked_start();
    preload();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
Owns the data memory port. Shares it between the pipeline MEM stage and a debug dump engine. While the CPU runs, MEM-stage accesses pass straight through. When the CPU is halted and the debug unit requests a dump, the block reads every slot in order and streams each word as bytes, LSB first, to the debug UART TX path over a valid/ready handshake.

Parameters:
ADDR_SIZE, 5, data memory address width; the dump covers 2**ADDR_SIZE slots.
SLOT_SIZE, 32, data memory word width; must be a multiple of BYTE_SIZE.
BYTE_SIZE, 8, width of the TX stream.

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_cpu_halted  in  1  CPU halted; a dump is only permitted while this is high
i_cpu_wr_rd  in  1  MEM stage write enable (1=write)
i_cpu_addr  in  ADDR_SIZE  MEM stage address
i_cpu_data  in  SLOT_SIZE  MEM stage write data
o_cpu_data  out  SLOT_SIZE  read data returned to MEM stage
o_mem_wr_rd  out  1  to data_memory i_wr_rd
o_mem_addr  out  ADDR_SIZE  to data_memory i_addr
o_mem_data  out  SLOT_SIZE  to data_memory i_data
i_mem_data  in  SLOT_SIZE  from data_memory o_data (combinational read)
i_dump_start  in  1  single-cycle dump request from the debug unit
o_tx_valid  out  1  byte available
o_tx_data  out  BYTE_SIZE  byte to transmit
i_tx_ready  in  1  TX accepts the byte this cycle
o_busy  out  1  dump in progress
o_dump_done  out  1  one-cycle pulse when the final byte is accepted

Behaviour:
- States: IDLE, LOAD, SEND, DONE. State, address counter (ADDR_SIZE), byte counter (log2(SLOT_SIZE/BYTE_SIZE)) and word register are all registered.
- Reset (async, any state) forces:
  - state=IDLE, counters=0, word register=0
  - o_tx_valid=0, o_tx_data=0, o_busy=0, o_dump_done=0
  - o_mem_wr_rd=0 while i_reset is high
  - A dump in flight is abandoned with no done pulse.
- IDLE memory routing, combinational:
  - o_mem_addr=i_cpu_addr, o_mem_data=i_cpu_data, o_cpu_data=i_mem_data
  - o_mem_wr_rd=i_cpu_wr_rd & ~i_cpu_halted, so a halted CPU never writes.
- Any state other than IDLE:
  - o_mem_wr_rd=0, o_mem_addr=address counter, o_mem_data=0, o_cpu_data=i_mem_data.
- IDLE->LOAD when i_dump_start & i_cpu_halted. Address counter is cleared to 0. i_dump_start with i_cpu_halted=0 is ignored.
- LOAD (1 cycle):
  - word register <= i_mem_data at the current address
  - byte counter <= 0
  - next state SEND
- SEND:
  - o_tx_valid=1; o_tx_data=word[byte_cnt*BYTE_SIZE +: BYTE_SIZE].
  - Valid and data hold stable until i_tx_ready.
  - On valid & ready, byte_cnt increments.
  - On the last byte: if address == 2**ADDR_SIZE-1 go to DONE, else increment address and go to LOAD.
  - No byte is ever dropped or duplicated.
- DONE (1 cycle): o_dump_done=1, then IDLE.
- o_busy=1 in LOAD, SEND and DONE.
- i_dump_start while busy is ignored; no restart and no queuing.
- i_cpu_halted falling mid-dump has no effect; the dump completes. CPU writes stay blocked until IDLE.
- Latency with i_tx_ready held high:
  - start sampled at edge k; LOAD during cycle k+1; first valid in cycle k+2
  - each word costs 1+SLOT_SIZE/BYTE_SIZE cycles
  - full dump = 2**ADDR_SIZE*(1+SLOT_SIZE/BYTE_SIZE)+1 cycles = 161 at defaults
- Address counter does not wrap; it stops at the final slot.

Test Plan:
- Passthrough: halted=0, CPU writes 0xDEADBEEF to addr 3, then reads addr 3 -> mem write strobed in that cycle; o_cpu_data=0xDEADBEEF; o_busy stays 0.
- Blocked start: halted=0, pulse i_dump_start -> state stays IDLE; o_busy=0; o_tx_valid never rises.
- Full dump, ready=1: preload slot n=n*0x01010101+0x10, halted=1, pulse start:
  - first bytes 0x10,0x00,0x00,0x00 (slot 0), then 0x11,0x01,0x01,0x01
  - 128 bytes total; o_dump_done high exactly 161 cycles after start
  - o_mem_wr_rd=0 throughout, even with i_cpu_wr_rd=1
- Backpressure: random i_tx_ready (seeded, 30% duty) -> o_tx_data never changes while valid & ~ready; byte stream identical to the ready=1 run.
- Reset mid-dump: assert i_reset during byte 2 of slot 7 -> immediately o_tx_valid=0, o_busy=0, no o_dump_done; a new start then begins again at slot 0.
- Start while busy: second i_dump_start pulse at slot 12 -> ignored; exactly 128 bytes and one done pulse.
